// File: rtl/uart_regfile_pkg.sv
// uart_regfile_pkg: response kinds, header bytes, error codes and encoder FSM states
package uart_regfile_pkg;
  typedef enum logic [1:0] {RESP_OK, RESP_DATA, RESP_ERR} resp_kind_t;
  localparam logic [7:0] HDR_OK = 8'h4B;
  localparam logic [7:0] HDR_DATA = 8'h44;
  localparam logic [7:0] HDR_ERR = 8'h45;
  localparam logic [7:0] ERR_UNKNOWN_CMD = 8'h01;
  localparam logic [7:0] ERR_BAD_ADDR = 8'h02;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_HI, ST_WAIT_LO} enc_state_t;
  typedef struct packed {
    resp_kind_t kind;
    logic [7:0] b1;
    logic [7:0] b2;
  } resp_rec_t;
endpackage

// File: rtl/resp_encoder_if.sv
// resp_encoder_if: response pulses from cmd_decoder and the uart_tx byte handshake
interface resp_encoder_if;
  logic       resp_ok;
  logic       resp_data;
  logic       resp_err;
  logic [7:0] resp_addr;
  logic [7:0] resp_data_byte;
  logic [7:0] resp_err_code;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       enc_idle;
  logic       resp_overflow;
  modport master (
    output resp_ok, resp_data, resp_err, resp_addr, resp_data_byte, resp_err_code, tx_busy,
    input  tx_start, tx_data, enc_idle, resp_overflow
  );
  modport slave (
    input  resp_ok, resp_data, resp_err, resp_addr, resp_data_byte, resp_err_code, tx_busy,
    output tx_start, tx_data, enc_idle, resp_overflow
  );
endinterface

// File: rtl/resp_fifo.sv
// resp_fifo: synchronous FIFO with wrap-bit pointers and full/empty flags
module resp_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
endmodule

// File: rtl/resp_encoder.sv
// resp_encoder: queues cmd_decoder responses and serializes them as byte frames to uart_tx
// Define RESP_CHKSUM_EN to append an XOR checksum byte to every frame.
module resp_encoder
  import uart_regfile_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ACK_BYTE   = HDR_OK,
  parameter logic [7:0] DATA_BYTE  = HDR_DATA,
  parameter logic [7:0] ERR_BYTE   = HDR_ERR
) (
  input logic clk,
  input logic rst_n,
  resp_encoder_if.slave bus
);
  logic push_req, push, pop, full, empty, tx_start;
  resp_rec_t in_rec, rd_rec, cur;
  enc_state_t state, state_d;
  logic [1:0] idx, last, base_last;
  logic [7:0] hdr, raw_byte, frame_byte;
  assign push_req = bus.resp_ok | bus.resp_data | bus.resp_err;
  // a full FIFO still takes the push when the head is popped in the same cycle
  assign push = push_req & (~full | pop);
  assign in_rec = '{
    kind: bus.resp_err ? RESP_ERR : bus.resp_data ? RESP_DATA : RESP_OK,
    b1:   bus.resp_err ? bus.resp_err_code : bus.resp_addr,
    b2:   bus.resp_data_byte
  };
  resp_fifo #(.WIDTH($bits(resp_rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (in_rec),
    .rd_en   (pop),
    .rd_data (rd_rec),
    .full    (full),
    .empty   (empty)
  );
  assign hdr = cur.kind == RESP_ERR ? ERR_BYTE : cur.kind == RESP_DATA ? DATA_BYTE : ACK_BYTE;
  assign base_last = cur.kind == RESP_DATA ? 2'd2 : cur.kind == RESP_ERR ? 2'd1 : 2'd0;
  assign raw_byte = idx == 2'd0 ? hdr : idx == 2'd1 ? cur.b1 : cur.b2;
`ifdef RESP_CHKSUM_EN
  logic [7:0] chk;
  assign last = base_last + 2'd1;
  assign frame_byte = idx == last ? chk : raw_byte;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk <= '0;
    else if (state == ST_LOAD) chk <= (idx == 2'd0 ? 8'h00 : chk) ^ frame_byte;
`else
  assign last = base_last;
  assign frame_byte = raw_byte;
`endif
  always_comb begin
    state_d = state;
    pop = 1'b0;
    tx_start = 1'b0;
    unique case (state)
      ST_IDLE: if (!empty) begin
        pop = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (!bus.tx_busy) begin
        tx_start = 1'b1;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: state_d = bus.tx_busy ? ST_WAIT_LO : ST_WAIT_HI;
      ST_WAIT_LO: state_d = bus.tx_busy ? ST_WAIT_LO : idx == last ? ST_IDLE : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end
  assign bus.tx_start = tx_start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cur <= '0;
      idx <= '0;
      bus.tx_data <= '0;
      bus.enc_idle <= 1'b1;
      bus.resp_overflow <= 1'b0;
    end else begin
      state <= state_d;
      if (pop) begin
        cur <= rd_rec;
        idx <= '0;
      end else if (state == ST_WAIT_LO && state_d == ST_LOAD) idx <= idx + 2'd1;
      if (state == ST_LOAD) bus.tx_data <= frame_byte;
      bus.enc_idle <= state_d == ST_IDLE && empty && !push_req;
      if (push_req && !push) bus.resp_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_resp_encoder.sv
// tb_resp_encoder: scoreboard bench with a uart_tx busy model; honours RESP_CHKSUM_EN
module tb_resp_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_busy = 1'b0;
  logic [3:0] bcnt = '0;
  int checks = 0;
  int passes = 0;
  int starts = 0;
  logic [7:0] exp_q[$];
  resp_encoder_if bus();
  resp_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #10 clk = ~clk;
  assign bus.tx_busy = force_busy || bcnt != 4'd0;
  always @(posedge clk)
    if (bus.tx_start && !bus.tx_busy) bcnt <= 4'd6;
    else if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk)
    if (rst_n && bus.tx_start) begin
      starts++;
      chk("busy_at_start", {7'b0, bus.tx_busy}, 8'h00);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_byte: got %h expected no byte", bus.tx_data);
      end else chk("tx_data", bus.tx_data, exp_q.pop_front());
    end
  task automatic exp_frame(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] x;
    x = b0;
    exp_q.push_back(b0);
    if (n > 1) begin exp_q.push_back(b1); x ^= b1; end
    if (n > 2) begin exp_q.push_back(b2); x ^= b2; end
`ifdef RESP_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask
  task automatic pulse(input logic ok, input logic d, input logic e,
                       input logic [7:0] a, input logic [7:0] db, input logic [7:0] c);
    bus.resp_ok = ok;
    bus.resp_data = d;
    bus.resp_err = e;
    bus.resp_addr = a;
    bus.resp_data_byte = db;
    bus.resp_err_code = c;
    @(posedge clk);
    #1;
    bus.resp_ok = 1'b0;
    bus.resp_data = 1'b0;
    bus.resp_err = 1'b0;
  endtask
  task automatic drain();
    int t;
    for (t = 0; t < 3000 && (exp_q.size() != 0 || bcnt != 4'd0); t++) @(negedge clk);
    if (t == 3000) begin
      checks++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge clk);
  endtask
  initial begin
    int k;
    int s0;
    bus.resp_ok = 1'b0;
    bus.resp_data = 1'b0;
    bus.resp_err = 1'b0;
    bus.resp_addr = '0;
    bus.resp_data_byte = '0;
    bus.resp_err_code = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx_start", {7'b0, bus.tx_start}, 8'h00);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_enc_idle", {7'b0, bus.enc_idle}, 8'h01);
    chk("rst_overflow", {7'b0, bus.resp_overflow}, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_frame(1, 8'h4B, 8'h00, 8'h00);
    pulse(1, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("enc_idle_drop", {7'b0, bus.enc_idle}, 8'h00);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.tx_start) break;
    end
    chk("latency", 8'(k), 8'd3);
    drain();
    chk("enc_idle_ok", {7'b0, bus.enc_idle}, 8'h01);
    exp_frame(3, 8'h44, 8'h03, 8'h5A);
    pulse(0, 1, 0, 8'h03, 8'h5A, 8'h00);
    drain();
    exp_frame(2, 8'h45, 8'h02, 8'h00);
    pulse(0, 0, 1, 8'h00, 8'h00, 8'h02);
    drain();
    exp_frame(2, 8'h45, 8'h01, 8'h00);
    pulse(0, 0, 1, 8'h00, 8'h00, 8'h01);
    drain();
    force_busy = 1'b1;
    exp_frame(1, 8'h4B, 8'h00, 8'h00);
    exp_frame(3, 8'h44, 8'h03, 8'hB3);
    exp_frame(2, 8'h45, 8'h01, 8'h00);
    pulse(1, 0, 0, 8'h00, 8'h00, 8'h00);
    pulse(0, 1, 0, 8'h03, 8'hB3, 8'h00);
    pulse(0, 0, 1, 8'h00, 8'h00, 8'h01);
    repeat (5) @(posedge clk);
    #1 force_busy = 1'b0;
    drain();
    chk("b2b_overflow", {7'b0, bus.resp_overflow}, 8'h00);
    exp_frame(2, 8'h45, 8'h01, 8'h00);
    pulse(1, 1, 1, 8'h03, 8'h5A, 8'h01);
    drain();
    exp_frame(3, 8'h44, 8'h07, 8'h08);
    pulse(1, 1, 0, 8'h07, 8'h08, 8'h00);
    drain();
    force_busy = 1'b1;
    repeat (5) exp_frame(1, 8'h4B, 8'h00, 8'h00);
    repeat (6) pulse(1, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("overflow_set", {7'b0, bus.resp_overflow}, 8'h01);
    @(posedge clk); #1 force_busy = 1'b0;
    drain();
    chk("overflow_sticky", {7'b0, bus.resp_overflow}, 8'h01);
    exp_frame(3, 8'h44, 8'h03, 8'h5A);
    s0 = starts;
    pulse(0, 1, 0, 8'h03, 8'h5A, 8'h00);
    for (k = 0; k < 200 && starts < s0 + 2; k++) @(negedge clk);
    chk("second_byte_started", 8'(starts - s0), 8'd2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_tx_start", {7'b0, bus.tx_start}, 8'h00);
    chk("midrst_enc_idle", {7'b0, bus.enc_idle}, 8'h01);
    chk("midrst_overflow", {7'b0, bus.resp_overflow}, 8'h00);
    chk("midrst_tx_data", bus.tx_data, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    s0 = starts;
    repeat (60) @(negedge clk);
    chk("no_bytes_after_reset", 8'(starts - s0), 8'd0);
    chk("idle_after_reset", {7'b0, bus.enc_idle}, 8'h01);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
